pipe_adder: RTL and testbench

- Parametrised, pipelined successor to the 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands.
- Splits the carry chain into STAGES registered chunks so wide adders close timing.
- Carries a valid/ready handshake with full backpressure.
- Reports carry-out and signed overflow alongside each result.
- Sits between operand producers and the lab result/display logic.

---
 rtl/pipe_adder.sv | 115 +++++++++++
 tb/tb_pipe_adder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract unit with a valid/ready handshake.
// The carry chain is cut into STAGES chunks of CHUNK bits. Each stage resolves
// one chunk and registers the partial sum, the carry into the next chunk and
// the operands still needed downstream. The last stage register is the output.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Reject parameter combinations that cannot split the carry chain evenly.
  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : gBadParams
    $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Per-stage pipeline registers.
  logic             stageValid_q [STAGES];
  logic [WIDTH-1:0] opA_q        [STAGES];
  logic [WIDTH-1:0] opB_q        [STAGES];
  logic [WIDTH-1:0] sum_q        [STAGES];
  logic             carry_q      [STAGES];

  // Inputs seen by each stage (ports for stage 0, previous register otherwise).
  logic             srcValid [STAGES];
  logic [WIDTH-1:0] srcA     [STAGES];
  logic [WIDTH-1:0] srcB     [STAGES];
  logic [WIDTH-1:0] srcSum   [STAGES];
  logic             srcCarry [STAGES];

  // Next-state values for the data registers of each stage.
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_d [STAGES];

  logic advance;

  // The whole pipeline moves together whenever the output slot can be vacated.
  assign advance  = out_ready || !stageValid_q[LAST];
  assign in_ready = advance;

  // Route stage inputs and resolve one chunk of the carry chain per stage.
  // Subtraction is A + ~B + 1, so stage 0 takes the inverted operand and
  // uses sub as its carry-in.
  always_comb begin
    logic [CHUNK:0] chunkSum;
    chunkSum    = '0;
    srcValid[0] = in_valid;
    srcA[0]     = a;
    srcB[0]     = sub ? ~b : b;
    srcSum[0]   = '0;
    srcCarry[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      srcValid[k] = stageValid_q[k-1];
      srcA[k]     = opA_q[k-1];
      srcB[k]     = opB_q[k-1];
      srcSum[k]   = sum_q[k-1];
      srcCarry[k] = carry_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunkSum = {1'b0, srcA[k][k*CHUNK +: CHUNK]}
               + {1'b0, srcB[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, srcCarry[k]};
      sum_d[k]                   = srcSum[k];
      sum_d[k][k*CHUNK +: CHUNK] = chunkSum[CHUNK-1:0];
      carry_d[k]                 = chunkSum[CHUNK];
    end
  end

  // Shift beats through the stages. Valid bits (bubbles included) move on
  // every advancing edge; data registers only load real beats so the outputs
  // keep their last result while out_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        stageValid_q[k] <= 1'b0;
        opA_q[k]        <= '0;
        opB_q[k]        <= '0;
        sum_q[k]        <= '0;
        carry_q[k]      <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        stageValid_q[k] <= srcValid[k];
        if (srcValid[k]) begin
          opA_q[k]   <= srcA[k];
          opB_q[k]   <= srcB[k];
          sum_q[k]   <= sum_d[k];
          carry_q[k] <= carry_d[k];
        end
      end
    end
  end

  // Signed overflow: operands of equal sign producing a result of the other sign.
  assign out_valid = stageValid_q[LAST];
  assign s         = sum_q[LAST];
  assign co        = carry_q[LAST];
  assign ovf       = (opA_q[LAST][WIDTH-1] == opB_q[LAST][WIDTH-1])
                  && (sum_q[LAST][WIDTH-1] != opA_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (WIDTH=8, STAGES=2).
// The driver pushes the expected result when a beat is accepted; an
// independent monitor pops and compares whenever a result is consumed.
module tb_pipe_adder;

  localparam int W  = 8;
  localparam int ST = 2;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] sv, input logic c, input logic o);
    mk = {sv, c, o};
  endfunction

  // Reference built from plain integer arithmetic rather than bit tricks.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    int   ua, ub, ur, sa, sb, sr;
    exp_t e;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sv) begin
      ur   = ua - ub;
      sr   = sa - sb;
      e.co = (ua >= ub);
    end else begin
      ur   = ua + ub;
      sr   = sa + sb;
      e.co = (ur >= (1 << W));
    end
    e.s   = W'(ur);
    e.ovf = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
    return e;
  endfunction

  // Monitor: compare every consumed result against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("result_s", 32'(s), 32'(e.s));
        checkOutput("result_co", 32'(co), 32'(e.co));
        checkOutput("result_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  // Present one beat (called at a rising edge) and hold it until accepted.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                               input logic rdy, input logic randReady, input exp_t e);
    bit   accepted;
    logic sampled;
    accepted = 0;
    for (int n = 0; n < 200 && !accepted; n++) begin
      #2;
      if (n == 0) begin
        a         = av;
        b         = bv;
        sub       = sv;
        in_valid  = 1'b1;
        out_ready = rdy;
      end else if (randReady) begin
        out_ready = 1'($urandom_range(0, 1));
      end
      #1 sampled = in_ready;
      @(posedge clk);
      if (sampled === 1'b1) begin
        expQ.push_back(e);
        accepted = 1;
      end
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleDrive(input logic rdy);
    #2;
    in_valid  = 1'b0;
    out_ready = rdy;
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    idleDrive(rdy);
    repeat (n) @(posedge clk);
  endtask

  // Synchronous reset, then check the post-reset state.
  task automatic doReset();
    #2;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_flush_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    expQ.delete();
    #2 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_s", 32'(s), 32'd0);
    checkOutput("rst_co", 32'(co), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  initial begin
    logic [W-1:0] corners [5];
    logic [W-1:0] av, bv;
    logic         sv;
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    $display("[TB] starting pipe_adder bench");
    doReset();

    // Carry crossing the chunk boundary, with latency check.
    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b1, 1'b0, mk(8'h10, 1'b0, 1'b0));
    idleDrive(1'b1);
    @(negedge clk);
    checkOutput("latency_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_valid", 32'(out_valid), 32'd1);
    checkOutput("latency_s", 32'(s), 32'h10);
    @(posedge clk);

    // Back-to-back stream: wrap-around and signed overflow.
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0));
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, mk(8'h80, 1'b0, 1'b1));
    idleDrive(1'b1);
    @(negedge clk);
    checkOutput("b2b_first_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    checkOutput("b2b_second_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    checkOutput("b2b_after_valid", 32'(out_valid), 32'd0);
    @(posedge clk);

    // Subtraction cases.
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b1, 1'b0, mk(8'hFE, 1'b0, 1'b0));
    applyStimulus(8'h80, 8'h01, 1'b1, 1'b1, 1'b0, mk(8'h7F, 1'b1, 1'b1));
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0));
    applyStimulus(8'h7F, 8'hFF, 1'b1, 1'b1, 1'b0, mk(8'h80, 1'b0, 1'b1));
    applyStimulus(8'h00, 8'h80, 1'b1, 1'b1, 1'b0, mk(8'h80, 1'b0, 1'b1));
    idleCycles(3, 1'b1);

    // Backpressure: two beats fill the pipe, the third waits at the input.
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, mk(8'h46, 1'b0, 1'b0));
    applyStimulus(8'hC8, 8'h50, 1'b0, 1'b0, 1'b0, mk(8'h18, 1'b1, 1'b0));
    #2;
    a         = 8'h40;
    b         = 8'h40;
    sub       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_s", 32'(s), 32'h46);
      checkOutput("stall_co", 32'(co), 32'd0);
    end
    @(posedge clk);
    applyStimulus(8'h40, 8'h40, 1'b0, 1'b1, 1'b0, mk(8'h80, 1'b0, 1'b1));
    idleCycles(4, 1'b1);

    // Reset with two beats in flight: neither may ever appear.
    applyStimulus(8'h11, 8'h22, 1'b0, 1'b1, 1'b0, mk(8'h33, 1'b0, 1'b0));
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b1, 1'b0, mk(8'h02, 1'b0, 1'b0));
    doReset();
    idleDrive(1'b1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("stale_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);

    // Boundary operands, both operations.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        for (int k = 0; k < 2; k++) begin
          av = corners[i];
          bv = corners[j];
          sv = 1'(k);
          applyStimulus(av, bv, sv, 1'b1, 1'b0, model(av, bv, sv));
        end
      end
    end

    // Random operands with random bubbles and backpressure.
    for (int i = 0; i < 1500; i++) begin
      av = W'($urandom);
      bv = W'($urandom);
      sv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) idleCycles(1, 1'($urandom_range(0, 1)));
      applyStimulus(av, bv, sv, 1'($urandom_range(0, 1)), 1'b1, model(av, bv, sv));
    end

    // Drain and confirm nothing is left over.
    idleDrive(1'b1);
    for (int n = 0; n < 100 && expQ.size() != 0; n++) @(posedge clk);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    @(negedge clk);
    checkOutput("idle_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
